i2c_slave_byte_engine: RTL and testbench



---
 rtl/i2c_slave_byte_engine.sv | 178 +++++++++++++++++
 tb/tb_i2c_slave_byte_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_byte_engine.sv
// Byte-level I2C slave engine: address match, receive/transmit shifting and
// ACK generation/checking. Drives SDA only through an open-drain pull-low enable.
module i2c_slave_byte_engine #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SDA_in,
  input  logic       SCL_in,
  input  logic       Start_Condition,
  input  logic       Stop_Condition,
  input  logic [7:0] Tx_Data,
  output logic       SDA_oe,
  output logic [7:0] Rx_Data,
  output logic       Rx_Valid,
  output logic       Tx_Load,
  output logic       Addressed,
  output logic       RW
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRxData,
    StRxAck,
    StTxData,
    StTxAck
  } state_e;

  state_e     state_q;
  logic       scl_q;
  logic [7:0] sreg_q;
  logic [2:0] bcnt_q;
  // Set once a byte (or master ACK) has been taken on a rise; acted on at the next fall.
  logic       done_q;
  // Delays Rx_Valid one cycle behind the Rx_Data update.
  logic       rx_pend_q;

  logic       scl_rise;
  logic       scl_fall;
  logic [7:0] shift_in;
  logic       unused_sreg_msb;

  assign scl_rise        = SCL_in & ~scl_q;
  assign scl_fall        = ~SCL_in & scl_q;
  assign shift_in        = {sreg_q[6:0], SDA_in};
  // Transmit bit 7 is taken straight from Tx_Data, so the register MSB is never read.
  assign unused_sreg_msb = sreg_q[7];

  // Bus-phase FSM with registered outputs; Start beats Stop beats SCL edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      scl_q     <= 1'b0;
      sreg_q    <= 8'h00;
      bcnt_q    <= 3'd0;
      done_q    <= 1'b0;
      rx_pend_q <= 1'b0;
      SDA_oe    <= 1'b0;
      Rx_Data   <= 8'h00;
      Rx_Valid  <= 1'b0;
      Tx_Load   <= 1'b0;
      Addressed <= 1'b0;
      RW        <= 1'b0;
    end else begin
      scl_q     <= SCL_in;
      Rx_Valid  <= rx_pend_q;
      rx_pend_q <= 1'b0;
      Tx_Load   <= 1'b0;
      if (Start_Condition) begin
        state_q   <= StAddr;
        bcnt_q    <= 3'd0;
        done_q    <= 1'b0;
        SDA_oe    <= 1'b0;
        Addressed <= 1'b0;
      end else if (Stop_Condition) begin
        state_q   <= StIdle;
        done_q    <= 1'b0;
        SDA_oe    <= 1'b0;
        Addressed <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
          end
          StAddr: begin
            if (scl_rise) begin
              sreg_q <= shift_in;
              bcnt_q <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                if (shift_in[7:1] == SLAVE_ADDR) begin
                  RW     <= shift_in[0];
                  done_q <= 1'b1;
                end else begin
                  state_q <= StIdle;
                end
              end
            end else if (scl_fall && done_q) begin
              done_q    <= 1'b0;
              state_q   <= StAddrAck;
              SDA_oe    <= 1'b1;
              Addressed <= 1'b1;
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              bcnt_q <= 3'd0;
              if (RW) begin
                state_q <= StTxData;
                sreg_q  <= Tx_Data;
                Tx_Load <= 1'b1;
                SDA_oe  <= ~Tx_Data[7];
              end else begin
                state_q <= StRxData;
                SDA_oe  <= 1'b0;
              end
            end
          end
          StRxData: begin
            if (scl_rise) begin
              sreg_q <= shift_in;
              bcnt_q <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                Rx_Data   <= shift_in;
                rx_pend_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end else if (scl_fall && done_q) begin
              done_q  <= 1'b0;
              state_q <= StRxAck;
              SDA_oe  <= 1'b1;
            end
          end
          StRxAck: begin
            if (scl_fall) begin
              SDA_oe  <= 1'b0;
              state_q <= StRxData;
              bcnt_q  <= 3'd0;
            end
          end
          StTxData: begin
            if (scl_rise) begin
              bcnt_q <= bcnt_q + 3'd1;
            end else if (scl_fall) begin
              if (bcnt_q != 3'd0) begin
                sreg_q <= {sreg_q[6:0], 1'b0};
                SDA_oe <= ~sreg_q[6];
              end else begin
                SDA_oe  <= 1'b0;
                state_q <= StTxAck;
              end
            end
          end
          StTxAck: begin
            if (scl_rise) begin
              if (SDA_in) begin
                state_q   <= StIdle;
                Addressed <= 1'b0;
                SDA_oe    <= 1'b0;
              end else begin
                done_q <= 1'b1;
              end
            end else if (scl_fall && done_q) begin
              done_q  <= 1'b0;
              sreg_q  <= Tx_Data;
              Tx_Load <= 1'b1;
              SDA_oe  <= ~Tx_Data[7];
              bcnt_q  <= 3'd0;
              state_q <= StTxData;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench for i2c_slave_byte_engine: a bit-level I2C master drives frames and a
// frame-level model predicts ACKs, received bytes, transmitted bits and pulse counts.
module tb_i2c_slave_byte_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       start_c = 1'b0;
  logic       stop_c = 1'b0;
  logic [7:0] Tx_Data;
  logic       sda_bus;
  logic       SDA_oe;
  logic [7:0] Rx_Data;
  logic       Rx_Valid;
  logic       Tx_Load;
  logic       Addressed;
  logic       RW;

  int checks = 0;
  int errors = 0;

  // Monitor-owned bookkeeping
  int         rxv_cnt = 0;
  int         txl_cnt = 0;
  int         oe_cycles = 0;
  int         mon_bad = 0;
  logic       rxv_prev = 1'b0;
  logic       txl_prev = 1'b0;
  logic [7:0] rx_log [256];

  // Stimulus-owned transmit source
  logic [7:0] tx_arr [8];
  int         tx_base = 0;
  logic [2:0] tx_idx;
  logic [7:0] byte_buf [8];

  assign sda_bus = m_sda & ~SDA_oe;
  assign tx_idx  = 3'(txl_cnt - tx_base);
  assign Tx_Data = tx_arr[tx_idx];

  i2c_slave_byte_engine #(.SLAVE_ADDR(7'h50)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .SDA_in          (sda_bus),
    .SCL_in          (scl),
    .Start_Condition (start_c),
    .Stop_Condition  (stop_c),
    .Tx_Data         (Tx_Data),
    .SDA_oe          (SDA_oe),
    .Rx_Data         (Rx_Data),
    .Rx_Valid        (Rx_Valid),
    .Tx_Load         (Tx_Load),
    .Addressed       (Addressed),
    .RW              (RW)
  );

  always #5 CLK = ~CLK;

  // Log pulses and flag any over-long or overlapping Rx_Valid/Tx_Load.
  always @(negedge CLK) begin
    if (Rx_Valid) begin
      rx_log[rxv_cnt[7:0]] <= Rx_Data;
      rxv_cnt <= rxv_cnt + 1;
    end
    if (Tx_Load) txl_cnt <= txl_cnt + 1;
    if (SDA_oe) oe_cycles <= oe_cycles + 1;
    if ((Rx_Valid && Tx_Load) || (Rx_Valid && rxv_prev) || (Tx_Load && txl_prev))
      mon_bad <= mon_bad + 1;
    rxv_prev <= Rx_Valid;
    txl_prev <= Tx_Load;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One SCL period (16 CLK); returns the bus value sampled mid-high.
  task automatic xfer_bit(input logic m, output logic b);
    cyc(4); m_sda = m;
    cyc(4); scl = 1'b1;
    cyc(4); b = sda_bus;
    cyc(4); scl = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] m, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(m[i], b);
      r[i] = b;
    end
  endtask

  task automatic send_start();
    if (scl == 1'b0) begin
      cyc(4); m_sda = 1'b1;
      cyc(4); scl = 1'b1;
      cyc(4);
    end
    m_sda = 1'b0;
    cyc(2); start_c = 1'b1;
    cyc(1); start_c = 1'b0;
    cyc(4); scl = 1'b0;
  endtask

  task automatic send_stop();
    cyc(4); m_sda = 1'b0;
    cyc(4); scl = 1'b1;
    cyc(4); m_sda = 1'b1;
    cyc(2); stop_c = 1'b1;
    cyc(1); stop_c = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    cyc(3);
    checks++; if (SDA_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", SDA_oe);
    if (SDA_oe !== 1'b0) errors++;
    RST = 1'b0;
    cyc(2);
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", SDA_oe); end
    checks++; if (Rx_Data !== 8'h00) begin errors++; $display("FAIL rst_rxd: got %h want 00", Rx_Data); end
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL rst_rxv: got %b want 0", Rx_Valid); end
    checks++; if (Tx_Load !== 1'b0) begin errors++; $display("FAIL rst_txl: got %b want 0", Tx_Load); end
    checks++; if (Addressed !== 1'b0) begin errors++; $display("FAIL rst_adr: got %b want 0", Addressed); end
    checks++; if (RW !== 1'b0) begin errors++; $display("FAIL rst_rw: got %b want 0", RW); end
  endtask

  // Write frame: the model says only address 0x50 is ACKed and every byte then lands in Rx_Data.
  task automatic test_write_frame(input logic [6:0] addr, input int n, input string tag);
    logic b;
    logic [7:0] rb;
    logic hit;
    int rx_base, oe_base, bad_base;
    hit = (addr == 7'h50);
    rx_base = rxv_cnt; oe_base = oe_cycles; bad_base = mon_bad;
    send_start();
    xfer_byte({addr, 1'b0}, rb);
    xfer_bit(1'b1, b);
    checks++;
    if (b !== ~hit) begin errors++; $display("FAIL %s addr_ack: got %b want %b", tag, b, ~hit); end
    checks++;
    if (Addressed !== hit) begin
      errors++; $display("FAIL %s addressed: got %b want %b", tag, Addressed, hit);
    end
    for (int i = 0; i < n; i++) begin
      xfer_byte(byte_buf[i], rb);
      xfer_bit(1'b1, b);
      checks++;
      if (b !== ~hit) begin errors++; $display("FAIL %s data_ack%0d: got %b want %b", tag, i, b, ~hit); end
    end
    send_stop();
    checks++;
    if (rxv_cnt - rx_base != (hit ? n : 0)) begin
      errors++; $display("FAIL %s rx_valid_count: got %0d want %0d", tag, rxv_cnt - rx_base, hit ? n : 0);
    end
    if (hit) begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_log[8'(rx_base + i)] !== byte_buf[i]) begin
          errors++;
          $display("FAIL %s rx_data%0d: got %h want %h", tag, i, rx_log[8'(rx_base + i)], byte_buf[i]);
        end
      end
    end else begin
      checks++;
      if (oe_cycles != oe_base) begin
        errors++; $display("FAIL %s oe_quiet: got %0d cycles want 0", tag, oe_cycles - oe_base);
      end
    end
    checks++;
    if (Addressed !== 1'b0) begin errors++; $display("FAIL %s addr_after_stop: got %b want 0", tag, Addressed); end
    checks++;
    if (mon_bad != bad_base) begin errors++; $display("FAIL %s pulse_shape: got %0d bad want 0", tag, mon_bad - bad_base); end
  endtask

  // Read frame of n bytes from tx_arr; master ACKs all but the last, which it NACKs.
  task automatic test_read_frame(input logic [6:0] addr, input int n, input string tag);
    logic b;
    logic [7:0] rb, want;
    logic hit;
    int bad_base, txl_base;
    hit = (addr == 7'h50);
    bad_base = mon_bad;
    tx_base = txl_cnt;
    txl_base = txl_cnt;
    send_start();
    xfer_byte({addr, 1'b1}, rb);
    xfer_bit(1'b1, b);
    checks++;
    if (b !== ~hit) begin errors++; $display("FAIL %s addr_ack: got %b want %b", tag, b, ~hit); end
    if (hit) begin
      checks++;
      if (RW !== 1'b1) begin errors++; $display("FAIL %s rw: got %b want 1", tag, RW); end
    end
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'hFF, rb);
      want = hit ? tx_arr[i] : 8'hFF;
      checks++;
      if (rb !== want) begin errors++; $display("FAIL %s tx_byte%0d: got %h want %h", tag, i, rb, want); end
      xfer_bit((i == n - 1) ? 1'b1 : 1'b0, b);
    end
    checks++;
    if (Addressed !== 1'b0) begin errors++; $display("FAIL %s addr_after_nack: got %b want 0", tag, Addressed); end
    checks++;
    if (txl_cnt - txl_base != (hit ? n : 0)) begin
      errors++; $display("FAIL %s tx_load_count: got %0d want %0d", tag, txl_cnt - txl_base, hit ? n : 0);
    end
    send_stop();
    checks++;
    if (mon_bad != bad_base) begin errors++; $display("FAIL %s pulse_shape: got %0d bad want 0", tag, mon_bad - bad_base); end
  endtask

  task automatic test_repeated_start();
    logic b;
    logic [7:0] rb;
    tx_arr[0] = 8'($urandom);
    tx_arr[1] = 8'($urandom);
    send_start();
    xfer_byte(8'hA0, rb);
    xfer_bit(1'b1, b);
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL rs wr_ack: got %b want 0", b); end
    tx_base = txl_cnt;
    send_start();
    xfer_byte(8'hA1, rb);
    xfer_bit(1'b1, b);
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL rs rd_ack: got %b want 0", b); end
    checks++; if (RW !== 1'b1) begin errors++; $display("FAIL rs rw: got %b want 1", RW); end
    cyc(1);
    checks++; if (Tx_Load !== 1'b1) begin errors++; $display("FAIL rs tx_load_edge: got %b want 1", Tx_Load); end
    checks++;
    if (SDA_oe !== ~tx_arr[0][7]) begin
      errors++; $display("FAIL rs first_bit_oe: got %b want %b", SDA_oe, ~tx_arr[0][7]);
    end
    xfer_byte(8'hFF, rb);
    checks++; if (rb !== tx_arr[0]) begin errors++; $display("FAIL rs tx_byte: got %h want %h", rb, tx_arr[0]); end
    xfer_bit(1'b1, b);
    send_stop();
  endtask

  task automatic test_start_mid_tx();
    logic b;
    logic [7:0] rb;
    tx_arr[0] = 8'h00;
    tx_base = txl_cnt;
    send_start();
    xfer_byte(8'hA1, rb);
    xfer_bit(1'b1, b);
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, b);
    cyc(4); scl = 1'b1;
    cyc(4);
    checks++; if (SDA_oe !== 1'b1) begin errors++; $display("FAIL smt oe_before: got %b want 1", SDA_oe); end
    start_c = 1'b1;
    cyc(1); start_c = 1'b0;
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL smt oe_after: got %b want 0", SDA_oe); end
    checks++; if (Addressed !== 1'b0) begin errors++; $display("FAIL smt addressed: got %b want 0", Addressed); end
    m_sda = 1'b0;
    cyc(4); scl = 1'b0;
    // Slave must now be collecting an address: a fresh 0x50 write gets ACKed.
    xfer_byte(8'hA0, rb);
    xfer_bit(1'b1, b);
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL smt readdr_ack: got %b want 0", b); end
    xfer_byte(8'hC3, rb);
    xfer_bit(1'b1, b);
    send_stop();
    checks++; if (Rx_Data !== 8'hC3) begin errors++; $display("FAIL smt rx_data: got %h want c3", Rx_Data); end
  endtask

  task automatic test_reset_mid_rx();
    logic b;
    logic [7:0] rb;
    send_start();
    xfer_byte(8'hA0, rb);
    xfer_bit(1'b1, b);
    for (int i = 0; i < 4; i++) xfer_bit(i[0], b);
    checks++; if (Addressed !== 1'b1) begin errors++; $display("FAIL rmr pre_addressed: got %b want 1", Addressed); end
    #2 RST = 1'b1;
    #1;
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL rmr oe: got %b want 0", SDA_oe); end
    checks++; if (Rx_Data !== 8'h00) begin errors++; $display("FAIL rmr rxd: got %h want 00", Rx_Data); end
    checks++; if (Addressed !== 1'b0) begin errors++; $display("FAIL rmr adr: got %b want 0", Addressed); end
    checks++; if (RW !== 1'b0) begin errors++; $display("FAIL rmr rw: got %b want 0", RW); end
    checks++; if (Rx_Valid !== 1'b0 || Tx_Load !== 1'b0) begin
      errors++; $display("FAIL rmr pulses: got %b%b want 00", Rx_Valid, Tx_Load);
    end
    cyc(3);
    RST = 1'b0;
    cyc(3);
    byte_buf[0] = 8'($urandom);
    byte_buf[1] = 8'($urandom);
    test_write_frame(7'h50, 2, "after_reset");
  endtask

  initial begin
    logic [6:0] a;
    int n;
    for (int i = 0; i < 8; i++) tx_arr[i] = 8'h00;
    test_reset();

    byte_buf[0] = 8'h3C;
    test_write_frame(7'h50, 1, "wr50");
    byte_buf[0] = 8'h3C;
    test_write_frame(7'h51, 1, "wr51");

    tx_arr[0] = 8'hA5;
    tx_arr[1] = 8'h5A;
    test_read_frame(7'h50, 2, "rd50");

    for (int k = 0; k < 4; k++) begin
      a = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      if (k == 0) a = 7'h50;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) byte_buf[i] = 8'($urandom);
      test_write_frame(a, n, "wr_rand");
    end
    for (int k = 0; k < 3; k++) begin
      a = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom_range(0, 127));
      n = $urandom_range(1, 5);
      for (int i = 0; i < 8; i++) tx_arr[i] = 8'($urandom);
      test_read_frame(a, n, "rd_rand");
    end

    test_repeated_start();
    test_start_mid_tx();
    test_reset_mid_rx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
